// File: rtl/ff_bank_pkg.sv
// Shared mode encoding and the per-channel next-state rule for the multimode flip-flop bank.
package ff_bank_pkg;

  typedef enum logic [1:0] {
    MODE_T  = 2'b00,
    MODE_D  = 2'b01,
    MODE_JK = 2'b10,
    MODE_SR = 2'b11
  } mode_e;

  // a_e/b_e are the (optionally edge-qualified) inputs; a_lvl is the raw synchronised level used by D.
  function automatic logic ch_next(input mode_e mode, input logic q, input logic a_e,
                                   input logic b_e, input logic a_lvl);
    logic n;
    n = q;
    case (mode)
      MODE_T:  n = a_e ? ~q : q;
      MODE_D:  n = a_lvl;
      MODE_JK: begin
        case ({a_e, b_e})
          2'b10:   n = 1'b1;
          2'b01:   n = 1'b0;
          2'b11:   n = ~q;
          default: n = q;
        endcase
      end
      MODE_SR: begin
        case ({a_e, b_e})
          2'b10:   n = 1'b1;
          2'b01:   n = 1'b0;
          default: n = q;  // S=R=1 is illegal and holds; flagged separately
        endcase
      end
      default: n = q;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ff_sync.sv
// Single-bit synchroniser of configurable depth with asynchronous reset to 0; DEPTH=0 is a wire.
module ff_sync #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign q = d;
    end else begin : g_sync
      logic [DEPTH-1:0] stg;

      // NOTE: sequential state uses non-blocking assignments so every stage samples the old value.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stg <= '0;
        end else begin
          stg[0] <= d;
          for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
        end
      end

      assign q = stg[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/multimode_ff_bank.sv
// Bank of CH flip-flop channels sharing a T/D/JK/SR mode, with synchronised inputs,
// optional rising-edge qualification, parallel load, sticky SR-illegal flag and change counter.
module multimode_ff_bank
  import ff_bank_pkg::*;
#(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic             edge_en,
  input  logic [CH-1:0]    a,
  input  logic [CH-1:0]    b,
  input  logic             load,
  input  logic [CH-1:0]    load_val,
  input  logic             clr_err,
  output logic [CH-1:0]    q,
  output logic [CH-1:0]    qbar,
  output logic             err,
  output logic [CNT_W-1:0] chg_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CH-1:0] a_s, b_s, a_p, b_p, a_e, b_e, q_next;
  logic          err_set;
  mode_e         mode_q;

  for (genvar i = 0; i < CH; i++) begin : g_ch_sync
    ff_sync #(.DEPTH(SYNC_STAGES)) u_sync_a (.clk(clk), .rst_n(rst_n), .d(a[i]), .q(a_s[i]));
    ff_sync #(.DEPTH(SYNC_STAGES)) u_sync_b (.clk(clk), .rst_n(rst_n), .d(b[i]), .q(b_s[i]));
  end

  // Edge history tracks the synchronised inputs continuously, independent of mode/edge_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_p <= '0;
      b_p <= '0;
    end else begin
      a_p <= a_s;
      b_p <= b_s;
    end
  end

  assign mode_q = mode_e'(mode);
  assign a_e    = edge_en ? (a_s & ~a_p) : a_s;
  assign b_e    = edge_en ? (b_s & ~b_p) : b_s;

  // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    q_next = q;
    for (int i = 0; i < CH; i++) begin
      q_next[i] = load ? load_val[i] : ch_next(mode_q, q[i], a_e[i], b_e[i], a_s[i]);
    end
  end

  assign err_set = (mode_q == MODE_SR) && !load && |(a_e & b_e);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q       <= '0;
      err     <= 1'b0;
      chg_cnt <= '0;
    end else begin
      q <= q_next;
      if (err_set)      err <= 1'b1;  // a new illegal event outranks a same-cycle clear
      else if (clr_err) err <= 1'b0;
      if ((q_next != q) && (chg_cnt != CNT_MAX)) chg_cnt <= chg_cnt + 1'b1;
    end
  end

  assign qbar = ~q;

endmodule

// File: tb/tb_multimode_ff_bank.sv
// Directed self-checking bench for multimode_ff_bank (CH=4, SYNC_STAGES=2) plus a CNT_W=3 copy.
module tb_multimode_ff_bank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] mode;
  logic       edge_en, load, clr_err;
  logic [3:0] a, b, load_val;
  logic [3:0] q, qbar;
  logic       err;
  logic [7:0] chg_cnt;
  logic [3:0] q3, qbar3;
  logic       err3;
  logic [2:0] cnt3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multimode_ff_bank #(.CH(4), .SYNC_STAGES(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .edge_en(edge_en), .a(a), .b(b),
    .load(load), .load_val(load_val), .clr_err(clr_err),
    .q(q), .qbar(qbar), .err(err), .chg_cnt(chg_cnt)
  );

  multimode_ff_bank #(.CH(4), .SYNC_STAGES(2), .CNT_W(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .edge_en(edge_en), .a(a), .b(b),
    .load(load), .load_val(load_val), .clr_err(clr_err),
    .q(q3), .qbar(qbar3), .err(err3), .chg_cnt(cnt3)
  );

  // Advance n rising edges; returns on the following falling edge, where outputs are sampled.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; mode = 2'b00; edge_en = 1'b0; load = 1'b0; clr_err = 1'b0;
    a = '0; b = '0; load_val = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (q !== 4'b0000) begin bad++; $display("FAIL reset_q: got %b expected 0000", q); end
    total++; if (qbar !== 4'b1111) begin bad++; $display("FAIL reset_qbar: got %b expected 1111", qbar); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b expected 0", err); end
    total++; if (chg_cnt !== 8'd0) begin bad++; $display("FAIL reset_cnt: got %0d expected 0", chg_cnt); end
    a = 4'b1111;
    tick(3);
    total++; if (q !== 4'b1111) begin bad++; $display("FAIL pre_async_q: got %b expected 1111", q); end
    #3 rst_n = 1'b0;
    #1;
    total++; if (q !== 4'b0000 || qbar !== 4'b1111) begin
      bad++; $display("FAIL async_reset_q: got q=%b qbar=%b expected 0000/1111", q, qbar);
    end
    total++; if (chg_cnt !== 8'd0) begin bad++; $display("FAIL async_reset_cnt: got %0d expected 0", chg_cnt); end
    // Held-high pin across reset release: edge detected only once the synchroniser refills.
    a = 4'b0001; edge_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);
    total++; if (q !== 4'b0000) begin bad++; $display("FAIL post_reset_fill: got %b expected 0000", q); end
    tick(1);
    total++; if (q !== 4'b0001) begin bad++; $display("FAIL post_reset_edge: got %b expected 0001", q); end
    tick(2);
    total++; if (q !== 4'b0001) begin bad++; $display("FAIL post_reset_hold: got %b expected 0001", q); end
  endtask

  task automatic test_t_mode();
    logic [3:0] exp_lvl [5];
    logic [3:0] exp_edg [5];
    exp_lvl = '{4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0001};
    exp_edg = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001};
    do_reset();
    mode = 2'b00; edge_en = 1'b0; a = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      total++; if (q !== exp_lvl[k]) begin
        bad++; $display("FAIL t_level_edge%0d: got %b expected %b", k + 1, q, exp_lvl[k]);
      end
    end
    do_reset();
    mode = 2'b00; edge_en = 1'b1; a = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      total++; if (q !== exp_edg[k]) begin
        bad++; $display("FAIL t_edge_edge%0d: got %b expected %b", k + 1, q, exp_edg[k]);
      end
    end
    total++; if (chg_cnt !== 8'd1) begin bad++; $display("FAIL t_edge_cnt: got %0d expected 1", chg_cnt); end
  endtask

  task automatic test_d_mode();
    do_reset();
    mode = 2'b01; edge_en = 1'b1; a = 4'b1011;
    tick(2);
    total++; if (q !== 4'b0000) begin bad++; $display("FAIL d_latency: got %b expected 0000", q); end
    tick(2);
    total++; if (q !== 4'b1011) begin bad++; $display("FAIL d_level: got %b expected 1011", q); end
  endtask

  task automatic test_jk();
    do_reset();
    mode = 2'b10; a = 4'b1010; b = 4'b0110;
    tick(3);
    total++; if (q !== 4'b1010) begin bad++; $display("FAIL jk_first: got %b expected 1010", q); end
    tick(1);
    total++; if (q !== 4'b1000) begin bad++; $display("FAIL jk_toggle: got %b expected 1000", q); end
  endtask

  task automatic test_sr();
    do_reset();
    mode = 2'b11; a = 4'b0001; b = 4'b0001;
    tick(2);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL sr_err_early: got %b expected 0", err); end
    tick(1);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL sr_err_set: got %b expected 1", err); end
    total++; if (q !== 4'b0000) begin bad++; $display("FAIL sr_hold: got %b expected 0000", q); end
    clr_err = 1'b1;
    tick(1);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL sr_set_wins: got %b expected 1", err); end
    clr_err = 1'b0; a = '0; b = '0;
    tick(3);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL sr_sticky: got %b expected 1", err); end
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL sr_clear: got %b expected 0", err); end
    tick(1);
    total++; if (err !== 1'b0 || q !== 4'b0000) begin
      bad++; $display("FAIL sr_after_clear: got err=%b q=%b expected 0/0000", err, q);
    end
  endtask

  task automatic test_load();
    do_reset();
    mode = 2'b00; a = 4'b1111;
    tick(2);
    load = 1'b1; load_val = 4'b0101;
    tick(1);
    load = 1'b0;
    total++; if (q !== 4'b0101 || qbar !== 4'b1010) begin
      bad++; $display("FAIL load_wins: got q=%b qbar=%b expected 0101/1010", q, qbar);
    end
    tick(1);
    total++; if (q !== 4'b1010) begin bad++; $display("FAIL load_then_t: got %b expected 1010", q); end
    total++; if (chg_cnt !== 8'd2) begin bad++; $display("FAIL load_cnt: got %0d expected 2", chg_cnt); end
  endtask

  task automatic test_saturate();
    int exp;
    do_reset();
    mode = 2'b00; a = 4'b0001;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      exp = (k < 3) ? 0 : ((k - 2 > 7) ? 7 : k - 2);
      total++; if (cnt3 !== 3'(exp)) begin
        bad++; $display("FAIL sat_cnt_edge%0d: got %0d expected %0d", k, cnt3, exp);
      end
    end
    total++; if (chg_cnt !== 8'd18) begin bad++; $display("FAIL wide_cnt: got %0d expected 18", chg_cnt); end
  endtask

  initial begin
    test_reset();
    test_t_mode();
    test_d_mode();
    test_jk();
    test_sr();
    test_load();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
